// File: rtl/isp8_io_resp.sv
// isp8_io_resp: peripheral-side responder for the isp8 external I/O/memory strobes.
// CPU writes are queued in a small FIFO and replayed on a req/ack peripheral bus.
// A single CPU read waits behind the queued writes and returns its data on ext_din.
module isp8_io_resp #(
    parameter int PORT_AW     = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PORT_AW-1:0] ext_addr,
    input  logic [7:0]         ext_dout,
    input  logic               ext_io_wr,
    input  logic               ext_io_rd,
    input  logic               ext_mem_wr,
    input  logic               ext_mem_rd,
    output logic [7:0]         ext_din,
    output logic               ext_din_vld,
    output logic               ext_busy,
    output logic               ext_err,
    input  logic               err_clr,
    output logic               p_req,
    output logic               p_we,
    output logic               p_mem,
    output logic [PORT_AW-1:0] p_addr,
    output logic [7:0]         p_wdata,
    input  logic               p_ack,
    input  logic [7:0]         p_rdata
);

    // FIFO entry layout is {mem, addr, data}; the count is one bit wider than the pointers
    // so that a full FIFO can be told apart from an empty one.
    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam int              ENT_W    = PORT_AW + 9;
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [7:0]      TMO_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_REQ = 2'd1,
        RD_REQ = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENT_W-1:0]   fifo_head;

    logic               rd_pend;
    logic               rd_pend_mem;
    logic [PORT_AW-1:0] rd_pend_addr;

    logic [7:0]         tmo_cnt;

    logic               wr_any;
    logic               wr_mem;
    logic               rd_any;
    logic               rd_mem;
    logic               space_conflict;
    logic               push;
    logic               wr_drop;
    logic               rd_accept;
    logic               rd_drop;
    logic               err_set;

    logic               pop;
    logic               rd_issue;
    logic               req_end;
    logic               tmo_hit;

    logic               txn_mem;
    logic [PORT_AW-1:0] txn_addr;
    logic [7:0]         txn_wdata;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign fifo_head  = fifo_mem[rd_ptr];

    // Decode the CPU strobes: memory space wins a same-direction clash, and every
    // dropped or conflicting strobe (plus a peripheral timeout) raises the error flag.
    always_comb begin
        wr_any         = ext_io_wr | ext_mem_wr;
        wr_mem         = ext_mem_wr;
        rd_any         = ext_io_rd | ext_mem_rd;
        rd_mem         = ext_mem_rd;
        space_conflict = (ext_io_wr & ext_mem_wr) | (ext_io_rd & ext_mem_rd);
        push           = wr_any & (~fifo_full | pop);
        wr_drop        = wr_any & ~push;
        rd_accept      = rd_any & ~rd_pend;
        rd_drop        = rd_any & rd_pend;
        err_set        = wr_drop | rd_drop | space_conflict | tmo_hit;
    end

    // Bridge FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: drain queued writes before a pending read, and finish a
    // request either on p_ack or when the timeout counter reaches its last value.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        rd_issue   = 1'b0;
        req_end    = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = WR_REQ;
                end else if (rd_pend) begin
                    rd_issue   = 1'b1;
                    state_next = RD_REQ;
                end
            end
            WR_REQ, RD_REQ: begin
                if (p_ack) begin
                    req_end    = 1'b1;
                    state_next = IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    req_end    = 1'b1;
                    tmo_hit    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State-derived outputs: the request is live in either request state, and the
    // CPU sees busy while the FIFO is full or a read has not yet been answered.
    always_comb begin
        p_req    = (state == WR_REQ) || (state == RD_REQ);
        p_we     = (state == WR_REQ);
        ext_busy = fifo_full | rd_pend | (state == RD_REQ);
    end

    // Write FIFO storage; entries need no reset because the count gates their use.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {wr_mem, ext_addr, ext_dout};
        end
    end

    // FIFO pointers and occupancy; a push and pop in the same cycle leave the count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Read-pending slot: holds the single outstanding read until it completes or times out.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend      <= 1'b0;
            rd_pend_mem  <= 1'b0;
            rd_pend_addr <= '0;
        end else begin
            if (rd_accept) begin
                rd_pend      <= 1'b1;
                rd_pend_mem  <= rd_mem;
                rd_pend_addr <= ext_addr;
            end else if ((state == RD_REQ) && req_end) begin
                rd_pend <= 1'b0;
            end
        end
    end

    // Peripheral transaction register, loaded when the FSM launches a request and
    // held unchanged for the whole handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_mem   <= 1'b0;
            txn_addr  <= '0;
            txn_wdata <= '0;
        end else if (pop) begin
            txn_mem   <= fifo_head[ENT_W-1];
            txn_addr  <= fifo_head[ENT_W-2:8];
            txn_wdata <= fifo_head[7:0];
        end else if (rd_issue) begin
            txn_mem   <= rd_pend_mem;
            txn_addr  <= rd_pend_addr;
            txn_wdata <= '0;
        end
    end

    assign p_mem   = txn_mem;
    assign p_addr  = txn_addr;
    assign p_wdata = txn_wdata;

    // Timeout counter: cleared when a request starts, counts every cycle it waits for p_ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (pop || rd_issue) begin
            tmo_cnt <= '0;
        end else if (((state == WR_REQ) || (state == RD_REQ)) && !p_ack && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Read return: one-cycle valid after the read finishes; an abandoned read returns 0xFF.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_din     <= '0;
            ext_din_vld <= 1'b0;
        end else begin
            ext_din_vld <= 1'b0;
            if ((state == RD_REQ) && req_end) begin
                ext_din_vld <= 1'b1;
                ext_din     <= p_ack ? p_rdata : 8'hFF;
            end
        end
    end

    // Sticky error flag; a new error in the same cycle beats a clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_err <= 1'b0;
        end else if (err_set) begin
            ext_err <= 1'b1;
        end else if (err_clr) begin
            ext_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_isp8_io_resp.sv
// tb_isp8_io_resp: directed self-checking bench for isp8_io_resp with hand-computed expectations.
module tb_isp8_io_resp;

    logic       clk;
    logic       rst;
    logic [7:0] ext_addr;
    logic [7:0] ext_dout;
    logic       ext_io_wr;
    logic       ext_io_rd;
    logic       ext_mem_wr;
    logic       ext_mem_rd;
    logic [7:0] ext_din;
    logic       ext_din_vld;
    logic       ext_busy;
    logic       ext_err;
    logic       err_clr;
    logic       p_req;
    logic       p_we;
    logic       p_mem;
    logic [7:0] p_addr;
    logic [7:0] p_wdata;
    logic       p_ack;
    logic [7:0] p_rdata;

    int testsRun;
    int testsFailed;

    isp8_io_resp #(
        .PORT_AW(8),
        .FIFO_DEPTH(4),
        .ACK_TIMEOUT(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ext_addr(ext_addr),
        .ext_dout(ext_dout),
        .ext_io_wr(ext_io_wr),
        .ext_io_rd(ext_io_rd),
        .ext_mem_wr(ext_mem_wr),
        .ext_mem_rd(ext_mem_rd),
        .ext_din(ext_din),
        .ext_din_vld(ext_din_vld),
        .ext_busy(ext_busy),
        .ext_err(ext_err),
        .err_clr(err_clr),
        .p_req(p_req),
        .p_we(p_we),
        .p_mem(p_mem),
        .p_addr(p_addr),
        .p_wdata(p_wdata),
        .p_ack(p_ack),
        .p_rdata(p_rdata)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 ns after the next rising edge: inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hold the given strobes for exactly one cycle, then release them.
    task automatic applyStimulus(input logic ioWr, input logic memWr, input logic ioRd,
                                 input logic memRd, input logic [7:0] addr, input logic [7:0] data);
        ext_io_wr  = ioWr;
        ext_mem_wr = memWr;
        ext_io_rd  = ioRd;
        ext_mem_rd = memRd;
        ext_addr   = addr;
        ext_dout   = data;
        tick();
        ext_io_wr  = 1'b0;
        ext_mem_wr = 1'b0;
        ext_io_rd  = 1'b0;
        ext_mem_rd = 1'b0;
    endtask

    // Directed scenarios; cycle N is the cycle the strobe is driven.
    initial begin
        int highCycles;
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        ext_addr    = '0;
        ext_dout    = '0;
        ext_io_wr   = 1'b0;
        ext_io_rd   = 1'b0;
        ext_mem_wr  = 1'b0;
        ext_mem_rd  = 1'b0;
        err_clr     = 1'b0;
        p_ack       = 1'b0;
        p_rdata     = '0;

        repeat (3) tick();
        checkOutput("rst p_req", p_req, 0);
        checkOutput("rst p_we", p_we, 0);
        checkOutput("rst p_addr", p_addr, 0);
        checkOutput("rst ext_din_vld", ext_din_vld, 0);
        checkOutput("rst ext_busy", ext_busy, 0);
        checkOutput("rst ext_err", ext_err, 0);
        rst = 1'b0;
        tick();

        $display("[TB] single I/O write");
        applyStimulus(1, 0, 0, 0, 8'h12, 8'hA5);
        checkOutput("wr1 p_req N+1", p_req, 0);
        tick();
        checkOutput("wr1 p_req N+2", p_req, 1);
        checkOutput("wr1 p_we", p_we, 1);
        checkOutput("wr1 p_mem", p_mem, 0);
        checkOutput("wr1 p_addr", p_addr, 8'h12);
        checkOutput("wr1 p_wdata", p_wdata, 8'hA5);
        repeat (3) tick();
        p_ack = 1'b1;
        checkOutput("wr1 p_req held", p_req, 1);
        tick();
        p_ack = 1'b0;
        checkOutput("wr1 p_req after ack", p_req, 0);
        tick();
        checkOutput("wr1 p_req idle", p_req, 0);
        checkOutput("wr1 busy idle", ext_busy, 0);

        $display("[TB] single memory read");
        applyStimulus(0, 0, 0, 1, 8'h40, 8'h00);
        checkOutput("rd1 busy N+1", ext_busy, 1);
        checkOutput("rd1 p_req N+1", p_req, 0);
        tick();
        checkOutput("rd1 p_req N+2", p_req, 1);
        checkOutput("rd1 p_we", p_we, 0);
        checkOutput("rd1 p_mem", p_mem, 1);
        checkOutput("rd1 p_addr", p_addr, 8'h40);
        repeat (5) tick();
        p_ack   = 1'b1;
        p_rdata = 8'h3C;
        checkOutput("rd1 busy before ack", ext_busy, 1);
        checkOutput("rd1 vld before ack", ext_din_vld, 0);
        tick();
        p_ack   = 1'b0;
        p_rdata = 8'h00;
        checkOutput("rd1 vld", ext_din_vld, 1);
        checkOutput("rd1 ext_din", ext_din, 8'h3C);
        tick();
        checkOutput("rd1 vld one cycle", ext_din_vld, 0);
        checkOutput("rd1 busy done", ext_busy, 0);

        $display("[TB] three writes then a read");
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1, 0, 0, 0, 8'(i), 8'(i));
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h50, 8'h00);
        checkOutput("seq w1 p_req", p_req, 1);
        checkOutput("seq w1 p_addr", p_addr, 8'h01);
        checkOutput("seq w1 p_wdata", p_wdata, 8'h01);
        checkOutput("seq busy rd pend", ext_busy, 1);
        for (int i = 2; i <= 3; i++) begin
            p_ack = 1'b1;
            tick();
            p_ack = 1'b0;
            checkOutput("seq gap", p_req, 0);
            tick();
            checkOutput("seq wr p_req", p_req, 1);
            checkOutput("seq wr p_we", p_we, 1);
            checkOutput("seq wr p_addr", p_addr, 32'(i));
            checkOutput("seq wr p_wdata", p_wdata, 32'(i));
        end
        p_ack = 1'b1;
        tick();
        p_ack = 1'b0;
        checkOutput("seq gap before rd", p_req, 0);
        tick();
        checkOutput("seq rd p_req", p_req, 1);
        checkOutput("seq rd p_we", p_we, 0);
        checkOutput("seq rd p_addr", p_addr, 8'h50);
        p_ack   = 1'b1;
        p_rdata = 8'h77;
        tick();
        p_ack   = 1'b0;
        checkOutput("seq rd vld", ext_din_vld, 1);
        checkOutput("seq rd ext_din", ext_din, 8'h77);
        tick();

        $display("[TB] dual-space write strobe");
        applyStimulus(1, 1, 0, 0, 8'h20, 8'h5A);
        checkOutput("dual err", ext_err, 1);
        tick();
        checkOutput("dual p_req", p_req, 1);
        checkOutput("dual p_mem wins", p_mem, 1);
        checkOutput("dual p_addr", p_addr, 8'h20);
        p_ack = 1'b1;
        tick();
        p_ack   = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("dual err cleared", ext_err, 0);
        tick();

        $display("[TB] FIFO overflow");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 0, 8'hA0 + 8'(i), 8'hB0 + 8'(i));
        end
        checkOutput("ovf busy full", ext_busy, 1);
        checkOutput("ovf no err yet", ext_err, 0);
        checkOutput("ovf head p_addr", p_addr, 8'hA0);
        applyStimulus(1, 0, 0, 0, 8'hA5, 8'hB5);
        checkOutput("ovf err set", ext_err, 1);
        checkOutput("ovf busy", ext_busy, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("ovf err cleared", ext_err, 0);
        for (int i = 1; i <= 4; i++) begin
            p_ack = 1'b1;
            tick();
            p_ack = 1'b0;
            checkOutput("ovf gap", p_req, 0);
            tick();
            checkOutput("ovf drain p_req", p_req, 1);
            checkOutput("ovf drain p_addr", p_addr, 32'hA0 + 32'(i));
            checkOutput("ovf drain p_wdata", p_wdata, 32'hB0 + 32'(i));
        end
        p_ack = 1'b1;
        tick();
        p_ack = 1'b0;
        tick();
        checkOutput("ovf dropped not issued", p_req, 0);
        checkOutput("ovf busy empty", ext_busy, 0);

        $display("[TB] read timeout");
        applyStimulus(0, 0, 1, 0, 8'h33, 8'h00);
        tick();
        checkOutput("tmo p_req start", p_req, 1);
        highCycles = 0;
        while (p_req && highCycles < 300) begin
            highCycles++;
            tick();
        end
        checkOutput("tmo p_req cycles", highCycles, 255);
        checkOutput("tmo vld", ext_din_vld, 1);
        checkOutput("tmo ext_din", ext_din, 8'hFF);
        checkOutput("tmo err", ext_err, 1);
        tick();
        checkOutput("tmo vld one cycle", ext_din_vld, 0);

        $display("[TB] reset during write request");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 8'hC0 + 8'(i), 8'hD0 + 8'(i));
        end
        checkOutput("mid p_req", p_req, 1);
        checkOutput("mid p_addr", p_addr, 8'hC0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid rst p_req", p_req, 0);
        checkOutput("mid rst p_we", p_we, 0);
        checkOutput("mid rst p_mem", p_mem, 0);
        checkOutput("mid rst p_addr", p_addr, 0);
        checkOutput("mid rst p_wdata", p_wdata, 0);
        checkOutput("mid rst ext_din", ext_din, 0);
        checkOutput("mid rst vld", ext_din_vld, 0);
        checkOutput("mid rst busy", ext_busy, 0);
        checkOutput("mid rst err", ext_err, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("mid no req after rst", p_req, 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/isp8_io_resp.md
Name: isp8_io_resp

Overview:
- Peripheral-side responder for the isp8 external I/O/memory strobe interface (ext_addr, ext_dout, ext_io_wr/rd, ext_mem_wr/rd).
- Buffers CPU writes in a small FIFO and bridges them onto a slow req/ack peripheral bus.
- Serves CPU reads in order behind pending writes and returns the data on ext_din with a one-cycle valid pulse.
- Sits between the isp8 core's I/O control outputs and the SoC peripheral fabric.

Parameters:
PORT_AW, 8, width of ext_addr and p_addr.
FIFO_DEPTH, 4, write-FIFO entries; power of 2, minimum 2.
ACK_TIMEOUT, 255, cycles a peripheral request may wait for p_ack before it is abandoned; range 1..255.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
ext_addr  in  PORT_AW  CPU address, valid while any strobe is high.
ext_dout  in  8  CPU write data.
ext_io_wr  in  1  I/O-space write strobe, one-cycle pulse.
ext_io_rd  in  1  I/O-space read strobe, one-cycle pulse.
ext_mem_wr  in  1  memory-space write strobe, one-cycle pulse.
ext_mem_rd  in  1  memory-space read strobe, one-cycle pulse.
ext_din  out  8  read data returned to the CPU.
ext_din_vld  out  1  one-cycle pulse; ext_din is valid in this cycle.
ext_busy  out  1  FIFO full, or a read is pending or in flight.
ext_err  out  1  sticky error flag.
err_clr  in  1  clears ext_err.
p_req  out  1  peripheral request.
p_we  out  1  1 = write, 0 = read.
p_mem  out  1  1 = memory space, 0 = I/O space.
p_addr  out  PORT_AW  peripheral address.
p_wdata  out  8  peripheral write data.
p_ack  in  1  peripheral completion, one cycle.
p_rdata  in  8  peripheral read data, valid with p_ack.

Behaviour:
- Reset (synchronous, active-high): every output is 0, the FIFO is emptied, the read-pending flag is cleared, FSM goes to IDLE, timeout counter is 0.
  - Reset mid-transaction: p_req is 0 from the next edge and the transaction is dropped silently, with no ext_din_vld.
- Write capture: ext_io_wr or ext_mem_wr pushes {mem, ext_addr, ext_dout}.
  - The push is accepted when the FIFO is not full, or when a pop occurs in the same cycle.
  - Otherwise the write is dropped and ext_err is set.
- Read capture: ext_io_rd or ext_mem_rd latches {mem, ext_addr} into the read-pending slot.
  - A read strobe while a read is already pending or in flight is dropped and sets ext_err.
- Simultaneous write and read strobe in one cycle: both are captured. The write is ordered first.
- Strobes from both spaces in one cycle: the mem strobe wins and ext_err is set.
- FSM states:
  - IDLE:
    - If the FIFO is not empty: pop the head into p_addr/p_wdata/p_mem, set p_we=1, p_req=1, go to WR_REQ.
    - Else if a read is pending: drive p_addr/p_mem, set p_we=0, p_req=1, go to RD_REQ.
    - Writes always drain before a pending read.
  - WR_REQ: hold p_req and all p_* outputs stable until p_ack.
    - On p_ack: p_req=0 next cycle, return to IDLE.
    - There is a mandatory one-cycle p_req-low gap between transactions.
  - RD_REQ: hold p_req until p_ack.
    - On p_ack: ext_din<=p_rdata and ext_din_vld=1 for exactly one cycle (cycle after p_ack), read-pending clears, return to IDLE.
  - Timeout: counter resets on entry to WR_REQ/RD_REQ and increments each cycle without p_ack.
    - On reaching ACK_TIMEOUT: p_req drops, ext_err is set, return to IDLE.
    - A timed-out read returns ext_din=8'hFF with ext_din_vld.
    - A timed-out write is discarded.
- p_ack outside WR_REQ/RD_REQ is ignored.
- Latency, with an idle FSM and empty FIFO:
  - Strobe at cycle N gives p_req high at N+2.
  - p_ack at cycle M gives ext_din_vld at M+1.
- ext_busy is combinational from registered state: (count==FIFO_DEPTH) | read_pending | (state==RD_REQ).
- ext_err: set has priority over err_clr in the same cycle.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is a separate log2(FIFO_DEPTH)+1-bit register.

Test Plan:
- Single I/O write addr 0x12 data 0xA5, p_ack 3 cycles after p_req -> p_req at N+2 with p_we=1, p_mem=0, p_addr=0x12, p_wdata=0xA5; p_req low the cycle after ack; FIFO empty.
- Memory read addr 0x40, p_rdata=0x3C with ack after 5 cycles -> p_we=0, p_mem=1; ext_din=0x3C with a single-cycle ext_din_vld; ext_busy high from N+1 until the vld cycle.
- Three writes (0x01..0x03) then a read, on back-to-back cycles, with p_ack withheld -> writes issue in order 0x01, 0x02, 0x03 with one-cycle gaps; the read issues only after the third write's ack.
- Five writes with p_ack held low, FIFO_DEPTH=4 -> the FIFO holds the last four after the first is popped. A sixth write while full is dropped, ext_busy=1, ext_err=1; err_clr clears ext_err.
- Read with p_ack never asserted, ACK_TIMEOUT=255 -> p_req drops after 255 cycles; ext_din=0xFF with vld; ext_err=1.
- rst asserted during WR_REQ with two FIFO entries -> p_req=0 next cycle; all outputs 0; no further requests issued after rst deasserts.
